// File: rtl/video_mono_filter.sv
// video_mono_filter
// Monochrome/tint filter for the Spectrum video path. It sits between the
// palette/ULA RGB output and the scandoubler/DAC.
//
// Pipeline (each stage advances only when ce=1):
//   stage 1 : weighted luma Y = (2R + 5G + B) >> 3, raw RGB, syncs, blank
//   stage 2 : display-mode mapping, blank forcing, output registers
//
// Mode requests are taken only on a vsync_in rising edge, so a whole frame is
// always shown in one mode. After reset the active mode is 0 (bypass).
//
// Modes: 0 bypass, 1 green, 2 amber, 3 grey, 4 inverted grey,
//        5 blue phosphor, 6/7 reserved (bypass).
//
// Optional build macro: MONO_SCANLINE_EN
//   Adds a line-parity flop (toggles on hsync_in rising edges, cleared on the
//   vsync_in rising edge). On odd lines, every mode other than 0 has each
//   output channel halved. The default build (macro undefined) has no parity
//   logic at all.

module video_mono_filter #(
    parameter int CW     = 3,
    parameter int MODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [CW-1:0]     ri,
    input  logic [CW-1:0]     gi,
    input  logic [CW-1:0]     bi,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_in,
    input  logic [MODE_W-1:0] mode_req,
    output logic [CW-1:0]     ro,
    output logic [CW-1:0]     go,
    output logic [CW-1:0]     bo,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out,
    output logic [MODE_W-1:0] mode_active
);

    // Sum needs three extra bits: the weights add up to 8.
    localparam int SW = CW + 3;

    localparam logic [MODE_W-1:0] MODE_BYPASS = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_GREEN  = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_AMBER  = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_GREY   = MODE_W'(3);
    localparam logic [MODE_W-1:0] MODE_INV    = MODE_W'(4);
    localparam logic [MODE_W-1:0] MODE_BLUE   = MODE_W'(5);

    // ------------------------------------------------------------------
    // Stage-1 signals
    // ------------------------------------------------------------------
    logic [SW-1:0] luma_sum;
    logic [CW-1:0] luma;

    logic [CW-1:0] y_s1;
    logic [CW-1:0] r_s1;
    logic [CW-1:0] g_s1;
    logic [CW-1:0] b_s1;
    logic          hs_s1;
    logic          vs_s1;
    logic          bl_s1;

    logic          vsync_prev;
    logic          vsync_rise;

    // ------------------------------------------------------------------
    // Stage-2 mapping signals
    // ------------------------------------------------------------------
    logic [CW-1:0] map_r;
    logic [CW-1:0] map_g;
    logic [CW-1:0] map_b;
    logic [CW-1:0] fin_r;
    logic [CW-1:0] fin_g;
    logic [CW-1:0] fin_b;

    // Weighted luma: 2R + 5G + B, truncated to CW bits after dividing by 8.
    always_comb begin
        luma_sum = (SW'(ri) << 1) + (SW'(gi) << 2) + SW'(gi) + SW'(bi);
        luma     = luma_sum[SW-1:3];
    end

    assign vsync_rise = vsync_in & ~vsync_prev;

    // Stage 1: capture luma, raw colour and the sync/blank bits of this pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_s1  <= '0;
            r_s1  <= '0;
            g_s1  <= '0;
            b_s1  <= '0;
            hs_s1 <= 1'b0;
            vs_s1 <= 1'b0;
            bl_s1 <= 1'b0;
        end else if (ce) begin
            y_s1  <= luma;
            r_s1  <= ri;
            g_s1  <= gi;
            b_s1  <= bi;
            hs_s1 <= hsync_in;
            vs_s1 <= vsync_in;
            bl_s1 <= blank_in;
        end
    end

    // Frame-boundary mode latch: mode_req is sampled only on the vsync rising
    // edge; stage 2 sees the new mode from the following ce cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev  <= 1'b0;
            mode_active <= MODE_BYPASS;
        end else if (ce) begin
            vsync_prev <= vsync_in;
            if (vsync_rise) begin
                mode_active <= mode_req;
            end
        end
    end

`ifdef MONO_SCANLINE_EN
    logic hsync_prev;
    logic line_par;
    logic par_s1;
    logic dim_line;

    // Line parity: toggles per hsync rising edge, restarts at each frame.
    // The parity of the line a pixel belongs to travels with it in stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_prev <= 1'b0;
            line_par   <= 1'b0;
            par_s1     <= 1'b0;
        end else if (ce) begin
            hsync_prev <= hsync_in;
            par_s1     <= line_par;
            if (vsync_rise) begin
                line_par <= 1'b0;
            end else if (hsync_in && !hsync_prev) begin
                line_par <= ~line_par;
            end
        end
    end

    assign dim_line = par_s1 && (mode_active != MODE_BYPASS);
`endif

    // Stage-2 colour mapping for the active mode, then blank/scanline forcing.
    always_comb begin
        map_r = r_s1;
        map_g = g_s1;
        map_b = b_s1;
        case (mode_active)
            MODE_GREEN: begin
                map_r = '0;
                map_g = y_s1;
                map_b = '0;
            end
            MODE_AMBER: begin
                map_r = y_s1;
                map_g = y_s1 >> 1;
                map_b = '0;
            end
            MODE_GREY: begin
                map_r = y_s1;
                map_g = y_s1;
                map_b = y_s1;
            end
            MODE_INV: begin
                map_r = ~y_s1;
                map_g = ~y_s1;
                map_b = ~y_s1;
            end
            MODE_BLUE: begin
                map_r = '0;
                map_g = y_s1 >> 1;
                map_b = y_s1;
            end
            default: begin
                map_r = r_s1;
                map_g = g_s1;
                map_b = b_s1;
            end
        endcase

        fin_r = map_r;
        fin_g = map_g;
        fin_b = map_b;
`ifdef MONO_SCANLINE_EN
        if (dim_line) begin
            fin_r = map_r >> 1;
            fin_g = map_g >> 1;
            fin_b = map_b >> 1;
        end
`endif
        if (bl_s1) begin
            fin_r = '0;
            fin_g = '0;
            fin_b = '0;
        end
    end

    // Stage 2: output registers; syncs are delayed unmodified to stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro        <= '0;
            go        <= '0;
            bo        <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b0;
        end else if (ce) begin
            ro        <= fin_r;
            go        <= fin_g;
            bo        <= fin_b;
            hsync_out <= hs_s1;
            vsync_out <= vs_s1;
            blank_out <= bl_s1;
        end
    end

endmodule
